// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: forwarding, ALU and EX/MEM pipeline register
module ex_stage #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             InValid,
  input  logic [3:0]       Alucontrol,
  input  logic [WIDTH-1:0] ReadData1,
  input  logic [WIDTH-1:0] ReadData2,
  input  logic [WIDTH-1:0] Imm,
  input  logic             AluSrc,
  input  logic [RADDR-1:0] RsAddr,
  input  logic [RADDR-1:0] RtAddr,
  input  logic [RADDR-1:0] RdAddr,
  input  logic             RegWriteIn,
  input  logic             MemReadIn,
  input  logic             MemWriteIn,
  input  logic             MemToRegIn,
  input  logic             WbRegWrite,
  input  logic [RADDR-1:0] WbRd,
  input  logic [WIDTH-1:0] WbData,
  input  logic             Stall,
  input  logic             Flush,
  output logic             ExValid,
  output logic [WIDTH-1:0] ExAluResult,
  output logic [WIDTH-1:0] ExWriteData,
  output logic [RADDR-1:0] ExRd,
  output logic             ExRegWrite,
  output logic             ExMemRead,
  output logic             ExMemWrite,
  output logic             ExMemToReg,
  output logic             ExZero,
  output logic             ExOverflow
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] alu_q, alu_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [RADDR-1:0] rd_q, rd_d;
  logic             regwrite_q, regwrite_d;
  logic             memread_q, memread_d;
  logic             memwrite_q, memwrite_d;
  logic             memtoreg_q, memtoreg_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic             ex_fwd_ok, wb_fwd_ok;
  logic [WIDTH-1:0] op_a, fwd_b, op_b;
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf;

  // A load's EX/MEM value is an address, not data, so it must never be forwarded.
  assign ex_fwd_ok = valid_q & regwrite_q & ~memread_q & (rd_q != '0);
  assign wb_fwd_ok = WbRegWrite & (WbRd != '0);

  always_comb begin
    op_a = ReadData1;
    if (ex_fwd_ok && (rd_q == RsAddr)) begin
      op_a = alu_q;
    end else if (wb_fwd_ok && (WbRd == RsAddr)) begin
      op_a = WbData;
    end
  end

  always_comb begin
    fwd_b = ReadData2;
    if (ex_fwd_ok && (rd_q == RtAddr)) begin
      fwd_b = alu_q;
    end else if (wb_fwd_ok && (WbRd == RtAddr)) begin
      fwd_b = WbData;
    end
  end

  assign op_b = AluSrc ? Imm : fwd_b;
  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (Alucontrol)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: begin
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  // Flush beats Stall; reset is applied in the register process itself.
  always_comb begin
    valid_d    = valid_q;
    alu_d      = alu_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    memtoreg_d = memtoreg_q;
    zero_d     = zero_q;
    ovf_d      = ovf_q;
    if (Flush) begin
      valid_d    = 1'b0;
      alu_d      = '0;
      wdata_d    = '0;
      rd_d       = '0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      zero_d     = 1'b0;
      ovf_d      = 1'b0;
    end else if (!Stall) begin
      valid_d    = InValid;
      alu_d      = alu_res;
      wdata_d    = fwd_b;
      rd_d       = RdAddr;
      regwrite_d = RegWriteIn & InValid;
      memread_d  = MemReadIn & InValid;
      memwrite_d = MemWriteIn & InValid;
      memtoreg_d = MemToRegIn & InValid;
      zero_d     = (alu_res == '0);
      ovf_d      = alu_ovf;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      valid_q    <= 1'b0;
      alu_q      <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      alu_q      <= alu_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      memtoreg_q <= memtoreg_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ExValid     = valid_q;
  assign ExAluResult = alu_q;
  assign ExWriteData = wdata_q;
  assign ExRd        = rd_q;
  assign ExRegWrite  = regwrite_q;
  assign ExMemRead   = memread_q;
  assign ExMemWrite  = memwrite_q;
  assign ExMemToReg  = memtoreg_q;
  assign ExZero      = zero_q;
  assign ExOverflow  = ovf_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed self-checking bench for ex_stage
module tb_ex_stage;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        InValid;
  logic [3:0]  Alucontrol;
  logic [31:0] ReadData1, ReadData2, Imm;
  logic        AluSrc;
  logic [4:0]  RsAddr, RtAddr, RdAddr;
  logic        RegWriteIn, MemReadIn, MemWriteIn, MemToRegIn;
  logic        WbRegWrite;
  logic [4:0]  WbRd;
  logic [31:0] WbData;
  logic        Stall, Flush;
  logic        ExValid;
  logic [31:0] ExAluResult, ExWriteData;
  logic [4:0]  ExRd;
  logic        ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg, ExZero, ExOverflow;

  int pass_cnt = 0;
  int total_cnt = 0;

  ex_stage #(.WIDTH(32), .RADDR(5)) dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .Alucontrol(Alucontrol),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .Imm(Imm), .AluSrc(AluSrc),
    .RsAddr(RsAddr), .RtAddr(RtAddr), .RdAddr(RdAddr),
    .RegWriteIn(RegWriteIn), .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
    .MemToRegIn(MemToRegIn), .WbRegWrite(WbRegWrite), .WbRd(WbRd), .WbData(WbData),
    .Stall(Stall), .Flush(Flush), .ExValid(ExValid), .ExAluResult(ExAluResult),
    .ExWriteData(ExWriteData), .ExRd(ExRd), .ExRegWrite(ExRegWrite),
    .ExMemRead(ExMemRead), .ExMemWrite(ExMemWrite), .ExMemToReg(ExMemToReg),
    .ExZero(ExZero), .ExOverflow(ExOverflow)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    InValid = 1'b0; Alucontrol = 4'b0010; ReadData1 = '0; ReadData2 = '0; Imm = '0;
    AluSrc = 1'b0; RsAddr = 5'd1; RtAddr = 5'd2; RdAddr = 5'd0;
    RegWriteIn = 1'b0; MemReadIn = 1'b0; MemWriteIn = 1'b0; MemToRegIn = 1'b0;
    WbRegWrite = 1'b0; WbRd = '0; WbData = '0; Stall = 1'b0; Flush = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic rw);
    InValid = 1'b1; Alucontrol = op; ReadData1 = a; ReadData2 = b;
    RsAddr = rs; RtAddr = rt; RdAddr = rd; RegWriteIn = rw; AluSrc = 1'b0;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    Rst = 1'b1;
    Alucontrol = 4'b0010; InValid = 1'b1; RegWriteIn = 1'b1; MemWriteIn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ReadData1 = $urandom; ReadData2 = $urandom; RdAddr = 5'($urandom_range(1, 31));
      step();
    end
    check("rst_valid", {31'd0, ExValid}, 32'd0);
    check("rst_result", ExAluResult, 32'd0);
    check("rst_ctrl", {28'd0, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg}, 32'd0);
    check("rst_rd_zero", {27'd0, ExRd}, 32'd0);
    check("rst_flags", {30'd0, ExZero, ExOverflow}, 32'd0);
    Rst = 1'b0;
    idle_inputs();

    issue(4'b0010, 32'd5, 32'd7, 5'd1, 5'd2, 5'd6, 1'b1);
    step();
    check("add5_7", ExAluResult, 32'd12);
    check("add5_7_zero", {31'd0, ExZero}, 32'd0);
    check("add5_7_valid", {31'd0, ExValid}, 32'd1);

    issue(4'b0010, 32'h8000_0000, 32'h7FFF_FFFF, 5'd1, 5'd2, 5'd7, 1'b0);
    step();
    check("add_res", ExAluResult, 32'hFFFF_FFFF);
    check("add_ovf", {31'd0, ExOverflow}, 32'd0);
    Alucontrol = 4'b0110; step();
    check("sub_res", ExAluResult, 32'h0000_0001);
    check("sub_ovf", {31'd0, ExOverflow}, 32'd1);
    Alucontrol = 4'b0000; step();
    check("and_res", ExAluResult, 32'd0);
    check("and_zero", {31'd0, ExZero}, 32'd1);
    Alucontrol = 4'b0001; step();
    check("or_res", ExAluResult, 32'hFFFF_FFFF);
    Alucontrol = 4'b0111; step();
    check("slt_res", ExAluResult, 32'd1);
    Alucontrol = 4'b1111; step();
    check("bad_op_res", ExAluResult, 32'd0);
    check("bad_op_flags", {30'd0, ExZero, ExOverflow}, 32'b10);

    issue(4'b0010, 32'h7FFF_FFFF, 32'd1, 5'd1, 5'd2, 5'd7, 1'b0);
    step();
    check("add_pos_ovf", {ExAluResult[31:1], ExOverflow}, {31'h4000_0000, 1'b1});

    issue(4'b0010, 32'd5, 32'h0000_00AA, 5'd1, 5'd2, 5'd7, 1'b0);
    AluSrc = 1'b1; Imm = 32'h10;
    step();
    check("imm_res", ExAluResult, 32'h15);
    check("imm_wdata", ExWriteData, 32'hAA);

    // Back-to-back dependency: EX/MEM beats MEM/WB for r3.
    issue(4'b0010, 32'd1, 32'd2, 5'd1, 5'd2, 5'd3, 1'b1);
    step();
    check("fwd_prod", ExAluResult, 32'd3);
    issue(4'b0110, 32'h100, 32'h100, 5'd3, 5'd3, 5'd4, 1'b1);
    WbRegWrite = 1'b1; WbRd = 5'd3; WbData = 32'd9;
    step();
    check("fwd_ex_res", ExAluResult, 32'd0);
    check("fwd_ex_zero", {31'd0, ExZero}, 32'd1);
    check("fwd_ex_wdata", ExWriteData, 32'd3);
    issue(4'b0010, 32'h100, 32'd1, 5'd3, 5'd0, 5'd8, 1'b0);
    step();
    check("fwd_wb_res", ExAluResult, 32'd10);
    WbRegWrite = 1'b0;

    issue(4'b0010, 32'h1000, 32'd0, 5'd1, 5'd0, 5'd5, 1'b1);
    MemReadIn = 1'b1; AluSrc = 1'b1; Imm = 32'd4;
    step();
    check("load_addr", ExAluResult, 32'h1004);
    check("load_memread", {31'd0, ExMemRead}, 32'd1);
    issue(4'b0010, 32'h11, 32'd0, 5'd5, 5'd0, 5'd9, 1'b0);
    MemReadIn = 1'b0; WbRegWrite = 1'b1; WbRd = 5'd5; WbData = 32'h55;
    step();
    check("load_nofwd", ExAluResult, 32'h55);

    issue(4'b0010, 32'd7, 32'd8, 5'd1, 5'd2, 5'd0, 1'b1);
    WbRegWrite = 1'b1; WbRd = 5'd0; WbData = 32'hDEAD;
    step();
    check("r0_write", ExAluResult, 32'd15);
    issue(4'b0010, 32'd0, 32'd0, 5'd0, 5'd0, 5'd10, 1'b0);
    step();
    check("r0_nofwd", ExAluResult, 32'd0);
    WbRegWrite = 1'b0;

    issue(4'b0010, 32'h20, 32'h2, 5'd1, 5'd2, 5'd11, 1'b1);
    MemWriteIn = 1'b1;
    step();
    check("pre_stall", ExAluResult, 32'h22);
    issue(4'b0001, 32'hF000, 32'h0F00, 5'd1, 5'd2, 5'd12, 1'b0);
    MemWriteIn = 1'b0; Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall_res%0d", i), ExAluResult, 32'h22);
      check($sformatf("stall_ctl%0d", i), {25'd0, ExRd, ExValid, ExRegWrite}, {25'd0, 5'd11, 2'b11});
    end
    check("stall_memwrite", {31'd0, ExMemWrite}, 32'd1);
    Flush = 1'b1;
    step();
    check("flush_ctl", {29'd0, ExValid, ExRegWrite, ExMemWrite}, 32'd0);
    check("flush_res", ExAluResult, 32'd0);
    Stall = 1'b0; Flush = 1'b0;

    issue(4'b0010, 32'd3, 32'd4, 5'd1, 5'd2, 5'd13, 1'b1);
    InValid = 1'b0; MemWriteIn = 1'b1;
    step();
    check("bubble_ctl", {29'd0, ExValid, ExRegWrite, ExMemWrite}, 32'd0);
    check("bubble_data", ExAluResult, 32'd7);

    issue(4'b0010, 32'd3, 32'd4, 5'd1, 5'd2, 5'd13, 1'b1);
    MemWriteIn = 1'b0;
    step();
    check("pre_rst", ExAluResult, 32'd7);
    Rst = 1'b1; Stall = 1'b1;
    step();
    check("midrst_res", ExAluResult, 32'd0);
    check("midrst_ctl", {26'd0, ExRd, ExValid}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
